// File: rtl/control_sequencer.sv
// ----------------------------------------------------------------------------
// control_sequencer
//
// Hardwired control unit for the datapath. It runs the fetch (T0..T2) and
// execute (T3..T6) steps of register-register ALU instructions. Each step
// drives the datapath strobes, the register-field selects and a one-hot ALU
// operation. The opcode is read back from the datapath IR once it is valid,
// which is from T3 onward.
//
// Ports
//   clk        in   rising-edge system clock
//   reset      in   asynchronous, active-low (0 = reset)
//   run        in   level; 1 = keep fetching, 0 = stop at next boundary
//   ir         in   [31:0] IR from datapath; op = ir[31:27]
//   PCout..HIin out datapath strobes
//   Gra/Grb/Grc out select ra/rb/rc field for register decode
//   Rin/Rout   out  write / drive the selected register
//   alu_op     out  [12:0] one-hot AND,OR,ADD,SUB,MUL,DIV,SHR,SHRA,SHL,
//                   ROR,ROL,NEG,NOT (bit 0..12)
//   busy       out  high in every state except IDLE and HALT
//   done       out  one-cycle pulse in the last step of an instruction
//   halted     out  high in HALT
//   illegal    out  sticky; an undefined opcode was decoded
//   icount     out  [CNT_W-1:0] retired instructions, saturating
// ----------------------------------------------------------------------------
module control_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [31:0]      ir,
    output logic             PCout,
    output logic             MARin,
    output logic             IncPC,
    output logic             PCin,
    output logic             Read,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Yin,
    output logic             Zin,
    output logic             Zlowout,
    output logic             Zhighout,
    output logic             LOin,
    output logic             HIin,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             Rin,
    output logic             Rout,
    output logic [12:0]      alu_op,
    output logic             busy,
    output logic             done,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] icount
);

    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6, HALT
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [4:0]  op;
    logic [12:0] op_onehot;
    logic        is_legal;
    logic        is_nop;
    logic        is_unary;
    logic        is_binary;
    logic        is_muldiv;
    logic        ir_unused;

    assign op        = ir[31:27];
    assign ir_unused = ^ir[26:0];

    // Opcode decode. Anything not listed leaves is_legal low.
    always_comb begin
        op_onehot = '0;
        is_legal  = 1'b1;
        is_nop    = 1'b0;
        case (op)
            5'b00101: op_onehot[0]  = 1'b1;   // AND
            5'b00110: op_onehot[1]  = 1'b1;   // OR
            5'b00011: op_onehot[2]  = 1'b1;   // ADD
            5'b00100: op_onehot[3]  = 1'b1;   // SUB
            5'b01111: op_onehot[4]  = 1'b1;   // MUL
            5'b10000: op_onehot[5]  = 1'b1;   // DIV
            5'b01001: op_onehot[6]  = 1'b1;   // SHR
            5'b01010: op_onehot[7]  = 1'b1;   // SHRA
            5'b01011: op_onehot[8]  = 1'b1;   // SHL
            5'b00111: op_onehot[9]  = 1'b1;   // ROR
            5'b01000: op_onehot[10] = 1'b1;   // ROL
            5'b10001: op_onehot[11] = 1'b1;   // NEG
            5'b10010: op_onehot[12] = 1'b1;   // NOT
            5'b11010: is_nop        = 1'b1;
            5'b11011: ;                       // HALT
            default:  is_legal      = 1'b0;
        endcase
    end

    assign is_unary  = op_onehot[11] | op_onehot[12];
    assign is_muldiv = op_onehot[4] | op_onehot[5];
    assign is_binary = (|op_onehot) & ~is_unary;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and Moore outputs. The instruction-final step chooses
    // between another fetch and IDLE, so run is only looked at there.
    always_comb begin
        next_state = state;
        PCout    = 1'b0;
        MARin    = 1'b0;
        IncPC    = 1'b0;
        PCin     = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        LOin     = 1'b0;
        HIin     = 1'b0;
        Gra      = 1'b0;
        Grb      = 1'b0;
        Grc      = 1'b0;
        Rin      = 1'b0;
        Rout     = 1'b0;
        alu_op   = '0;
        done     = 1'b0;
        halted   = 1'b0;
        case (state)
            IDLE: begin
                if (run) next_state = T0;
            end
            T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; PCin = 1'b1;
                next_state = T1;
            end
            T1: begin
                Read = 1'b1; MDRin = 1'b1;
                next_state = T2;
            end
            T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                next_state = T3;
            end
            T3: begin
                if (is_binary) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    next_state = T4;
                end else if (is_unary) begin
                    Grb = 1'b1; Rout = 1'b1; Zin = 1'b1;
                    alu_op = op_onehot;
                    next_state = T4;
                end else if (is_nop) begin
                    done = 1'b1;
                    next_state = run ? T0 : IDLE;
                end else begin
                    next_state = HALT;
                end
            end
            T4: begin
                if (is_unary) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; done = 1'b1;
                    next_state = run ? T0 : IDLE;
                end else begin
                    Grc = 1'b1; Rout = 1'b1; Zin = 1'b1;
                    alu_op = op_onehot;
                    next_state = T5;
                end
            end
            T5: begin
                Zlowout = 1'b1;
                if (is_muldiv) begin
                    LOin = 1'b1;
                    next_state = T6;
                end else begin
                    Gra = 1'b1; Rin = 1'b1; done = 1'b1;
                    next_state = run ? T0 : IDLE;
                end
            end
            T6: begin
                Zhighout = 1'b1; HIin = 1'b1; done = 1'b1;
                next_state = run ? T0 : IDLE;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE) && (state != HALT);

    // Sticky illegal flag, raised as the sequencer leaves T3 for HALT on
    // an undefined opcode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            illegal <= 1'b0;
        end else if (state == T3 && !is_legal) begin
            illegal <= 1'b1;
        end
    end

    // Retired-instruction counter; sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            icount <= '0;
        end else if (done && icount != {CNT_W{1'b1}}) begin
            icount <= icount + 1'b1;
        end
    end

endmodule
